// File: rtl/c5_sram_responder_pkg.sv
// Shared types for the c5 bus to 16-bit async SRAM responder: FSM states and
// the registered SRAM strobe bundle, plus the per-state strobe decode.
package c5_sram_responder_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LO     = 3'd1,
    ST_LO_REC = 3'd2,
    ST_HI     = 3'd3,
    ST_HI_REC = 3'd4,
    ST_ACK    = 3'd5
  } state_t;

  typedef struct packed {
    logic ce_n;
    logic oe_n;
    logic we_n;
    logic lb_n;
    logic ub_n;
    logic dq_oe;
  } sram_ctl_t;

  localparam sram_ctl_t CTL_IDLE = '{ce_n: 1'b1, oe_n: 1'b1, we_n: 1'b1,
                                     lb_n: 1'b1, ub_n: 1'b1, dq_oe: 1'b0};

  // Strobe pattern held while in state s; recovery states keep data driven
  // with we_n released so the SRAM sees its data hold time.
  function automatic sram_ctl_t ctl_for(input state_t s, input logic [3:0] we);
    sram_ctl_t  c;
    logic       rd;
    logic [1:0] be;
    c  = CTL_IDLE;
    rd = (we == 4'b0000);
    be = (s == ST_HI || s == ST_HI_REC) ? we[3:2] : we[1:0];
    case (s)
      ST_LO, ST_HI: begin
        c.ce_n  = 1'b0;
        c.oe_n  = ~rd;
        c.we_n  = rd;
        c.dq_oe = ~rd;
        c.lb_n  = rd ? 1'b0 : ~be[0];
        c.ub_n  = rd ? 1'b0 : ~be[1];
      end
      ST_LO_REC, ST_HI_REC: begin
        c.ce_n  = 1'b0;
        c.dq_oe = 1'b1;
        c.lb_n  = ~be[0];
        c.ub_n  = ~be[1];
      end
      default: c = CTL_IDLE;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/c5_sram_responder.sv
// c5 pipelined-bus target in front of a 16-bit async SRAM. Each 32-bit word is
// two sequential halfword accesses; one transaction in flight, stall while busy.
module c5_sram_responder
  import c5_sram_responder_pkg::*;
#(
  parameter int ADR_BITS    = 20,
  parameter int WAIT_CYCLES = 1
) (
  input  logic                I_clk,
  input  logic                I_rst_n,
  input  logic                I_cyc,
  input  logic                I_stb,
  input  logic [3:0]          I_we,
  input  logic [31:0]         I_adr,
  input  logic [31:0]         I_dat,
  output logic [31:0]         O_dat,
  output logic                O_stall,
  output logic                O_ack,
  output logic [ADR_BITS-2:0] O_sram_adr,
  output logic [15:0]         O_sram_dq,
  output logic                O_sram_dq_oe,
  input  logic [15:0]         I_sram_dq,
  output logic                O_sram_ce_n,
  output logic                O_sram_oe_n,
  output logic                O_sram_we_n,
  output logic                O_sram_lb_n,
  output logic                O_sram_ub_n
);

  localparam int CNT_W = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;

  state_t              state;
  sram_ctl_t           ctl_q;
  logic [CNT_W-1:0]    cnt;
  logic [ADR_BITS-3:0] adr_q;
  logic [3:0]          we_q;
  logic [31:0]         dat_q;
  logic [15:0]         rd_lo;
  logic [15:0]         rd_hi;
  logic                drop;

  logic is_wr;
  logic skip_hi;
  logic acc_skip_lo;
  logic cnt_done;
  logic unused;

  assign is_wr       = |we_q;
  assign skip_hi     = is_wr & ~|we_q[3:2];
  assign acc_skip_lo = (|I_we) & ~|I_we[1:0];
  assign cnt_done    = (cnt == CNT_W'(WAIT_CYCLES));
  // Upper address bits alias; byte offset is implied by the word access.
  assign unused      = ^{I_adr[31:ADR_BITS], I_adr[1:0]};

  assign O_stall      = (state != ST_IDLE);
  assign O_sram_ce_n  = ctl_q.ce_n;
  assign O_sram_oe_n  = ctl_q.oe_n;
  assign O_sram_we_n  = ctl_q.we_n;
  assign O_sram_lb_n  = ctl_q.lb_n;
  assign O_sram_ub_n  = ctl_q.ub_n;
  assign O_sram_dq_oe = ctl_q.dq_oe;

  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      state      <= ST_IDLE;
      ctl_q      <= CTL_IDLE;
      cnt        <= '0;
      adr_q      <= '0;
      we_q       <= '0;
      dat_q      <= '0;
      rd_lo      <= '0;
      rd_hi      <= '0;
      drop       <= 1'b0;
      O_sram_adr <= '0;
      O_sram_dq  <= '0;
      O_ack      <= 1'b0;
      O_dat      <= '0;
    end else begin
      O_ack <= 1'b0;
      O_dat <= '0;
      // Initiator walking away never tears an SRAM write; it only loses the ack.
      if (state != ST_IDLE && !I_cyc) drop <= 1'b1;
      case (state)
        ST_IDLE: begin
          if (I_cyc && I_stb) begin
            adr_q <= I_adr[ADR_BITS-1:2];
            we_q  <= I_we;
            dat_q <= I_dat;
            drop  <= 1'b0;
            cnt   <= '0;
            if (acc_skip_lo) begin
              state      <= ST_HI;
              ctl_q      <= ctl_for(ST_HI, I_we);
              O_sram_adr <= {I_adr[ADR_BITS-1:2], 1'b1};
              O_sram_dq  <= I_dat[31:16];
            end else begin
              state      <= ST_LO;
              ctl_q      <= ctl_for(ST_LO, I_we);
              O_sram_adr <= {I_adr[ADR_BITS-1:2], 1'b0};
              O_sram_dq  <= I_dat[15:0];
            end
          end
        end
        ST_LO: begin
          if (cnt_done) begin
            cnt <= '0;
            if (is_wr) begin
              state <= ST_LO_REC;
              ctl_q <= ctl_for(ST_LO_REC, we_q);
            end else begin
              rd_lo      <= I_sram_dq;
              state      <= ST_HI;
              ctl_q      <= ctl_for(ST_HI, we_q);
              O_sram_adr <= {adr_q, 1'b1};
              O_sram_dq  <= dat_q[31:16];
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_LO_REC: begin
          if (skip_hi) begin
            state <= ST_ACK;
            ctl_q <= CTL_IDLE;
          end else begin
            state      <= ST_HI;
            ctl_q      <= ctl_for(ST_HI, we_q);
            O_sram_adr <= {adr_q, 1'b1};
            O_sram_dq  <= dat_q[31:16];
          end
        end
        ST_HI: begin
          if (cnt_done) begin
            cnt <= '0;
            if (is_wr) begin
              state <= ST_HI_REC;
              ctl_q <= ctl_for(ST_HI_REC, we_q);
            end else begin
              rd_hi <= I_sram_dq;
              state <= ST_ACK;
              ctl_q <= CTL_IDLE;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_HI_REC: begin
          state <= ST_ACK;
          ctl_q <= CTL_IDLE;
        end
        ST_ACK: begin
          state <= ST_IDLE;
          O_ack <= ~drop & I_cyc;
          O_dat <= is_wr ? 32'h0 : {rd_hi, rd_lo};
        end
        default: begin
          state <= ST_IDLE;
          ctl_q <= CTL_IDLE;
        end
      endcase
    end
  end

endmodule
